// File: rtl/voice_mix_ramp.sv
// Click-free crossfade between the dry and pitch-shifted samples ahead of the codec.
// The wet gain ramps one step per audio frame; each mix passes through a two-stage pipeline.
module voice_mix_ramp #(
  parameter int RAMP_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready,
  input  logic [15:0]          dry_in,
  input  logic [15:0]          wet_in,
  input  logic                 change_en,
  output logic [23:0]          play_data,
  output logic                 sample_valid,
  output logic                 fading,
  output logic [RAMP_LOG2:0]   gain
);

  localparam int W      = 16 + RAMP_LOG2 + 2;
  localparam int F_INT  = 1 << RAMP_LOG2;
  localparam int FM1_INT = F_INT - 1;
  localparam int ONE_INT = 1;
  localparam logic [RAMP_LOG2:0] GAIN_MAX    = F_INT[RAMP_LOG2:0];
  localparam logic [RAMP_LOG2:0] GAIN_MAX_M1 = FM1_INT[RAMP_LOG2:0];
  localparam logic [RAMP_LOG2:0] GAIN_ONE    = ONE_INT[RAMP_LOG2:0];

  typedef enum logic [1:0] {
    ST_BYPASS  = 2'd0,
    ST_FADE_UP = 2'd1,
    ST_WET     = 2'd2,
    ST_FADE_DN = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [RAMP_LOG2:0]   gain_q, gain_d;
  logic                 fading_q, fading_d;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (ready) begin
      case (state_q)
        ST_BYPASS:  if (change_en) state_d = ST_FADE_UP;
        ST_FADE_UP: begin
          if (!change_en)                 state_d = ST_FADE_DN;
          else if (gain_q >= GAIN_MAX_M1) state_d = ST_WET;
        end
        ST_WET:     if (!change_en) state_d = ST_FADE_DN;
        ST_FADE_DN: begin
          if (change_en)               state_d = ST_FADE_UP;
          else if (gain_q <= GAIN_ONE) state_d = ST_BYPASS;
        end
        default:    state_d = ST_BYPASS;
      endcase
      // The state being entered decides the step taken on this same strobe.
      case (state_d)
        ST_BYPASS:  gain_d = '0;
        ST_WET:     gain_d = GAIN_MAX;
        ST_FADE_UP: gain_d = (gain_q == GAIN_MAX) ? gain_q : gain_q + GAIN_ONE;
        ST_FADE_DN: gain_d = (gain_q == '0) ? gain_q : gain_q - GAIN_ONE;
        default:    gain_d = '0;
      endcase
    end
    fading_d = (state_d == ST_FADE_UP) || (state_d == ST_FADE_DN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BYPASS;
      gain_q   <= '0;
      fading_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      fading_q <= fading_d;
    end
  end

  // Stage 1 operands: both samples sign-extended, both weights zero-extended.
  logic signed [W-1:0]  wet_ext, dry_ext, w_wet, w_dry;
  logic [RAMP_LOG2:0]   dry_weight;
  logic signed [W-1:0]  prod_wet_d, prod_dry_d;

  always_comb begin
    dry_weight = GAIN_MAX - gain_q;
    wet_ext    = W'($signed(wet_in));
    dry_ext    = W'($signed(dry_in));
    w_wet      = W'(gain_q);
    w_dry      = W'(dry_weight);
    prod_wet_d = wet_ext * w_wet;
    prod_dry_d = dry_ext * w_dry;
  end

  logic signed [W-1:0]  prod_wet_q, prod_dry_q;
  logic                 valid1_q;
  logic signed [W-1:0]  sum_d, shifted_d;
  logic [23:0]          play_data_q;
  logic                 sample_valid_q;

  // The weights sum to F, so the shifted sum always fits back into 16 bits.
  always_comb begin
    sum_d     = prod_wet_q + prod_dry_q;
    shifted_d = sum_d >>> RAMP_LOG2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_wet_q     <= '0;
      prod_dry_q     <= '0;
      valid1_q       <= 1'b0;
      play_data_q    <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      valid1_q       <= ready;
      sample_valid_q <= valid1_q;
      if (ready) begin
        prod_wet_q <= prod_wet_d;
        prod_dry_q <= prod_dry_d;
      end
      if (valid1_q) play_data_q <= {shifted_d[15:0], 8'd0};
    end
  end

  assign play_data    = play_data_q;
  assign sample_valid = sample_valid_q;
  assign fading       = fading_q;
  assign gain         = gain_q;

endmodule

// File: tb/tb_voice_mix_ramp.sv
// Directed bench for voice_mix_ramp with a 4-frame fade (RAMP_LOG2 = 2).
module tb_voice_mix_ramp;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [15:0] dry_in, wet_in;
  logic        change_en;
  logic [23:0] play_data;
  logic        sample_valid;
  logic        fading;
  logic [2:0]  gain;

  int checks   = 0;
  int failures = 0;

  voice_mix_ramp #(.RAMP_LOG2(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .dry_in       (dry_in),
    .wet_in       (wet_in),
    .change_en    (change_en),
    .play_data    (play_data),
    .sample_valid (sample_valid),
    .fading       (fading),
    .gain         (gain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One strobe; checks gain/fading the cycle after, then the mixed word two cycles after.
  task automatic frame(input string tag, input logic [15:0] d, input logic [15:0] w,
                       input logic ce, input logic [15:0] exp_mix,
                       input int exp_gain, input logic exp_fading);
    @(posedge clk); #1;
    check({tag, " idle_valid"}, 32'(sample_valid), 32'd0);
    ready = 1'b1; dry_in = d; wet_in = w; change_en = ce;
    @(posedge clk); #1;
    ready = 1'b0;
    check({tag, " gain"},   32'(gain),   32'(exp_gain));
    check({tag, " fading"}, 32'(fading), 32'(exp_fading));
    check({tag, " early_valid"}, 32'(sample_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, " valid"}, 32'(sample_valid), 32'd1);
    check({tag, " play"},  32'(play_data), 32'({exp_mix, 8'h00}));
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; dry_in = '0; wet_in = '0; change_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst play",   32'(play_data),    32'd0);
    check("rst valid",  32'(sample_valid), 32'd0);
    check("rst fading", 32'(fading),       32'd0);
    check("rst gain",   32'(gain),         32'd0);
    reset = 1'b0;

    frame("bypass", 16'd1000, -16'sd1000, 1'b0, 16'd1000, 0, 1'b0);

    // Fade up: mixes at g = 0,1,2,3,4
    frame("up1", 16'd1000, -16'sd1000, 1'b1, 16'd1000,   1, 1'b1);
    frame("up2", 16'd1000, -16'sd1000, 1'b1, 16'd500,    2, 1'b1);
    frame("up3", 16'd1000, -16'sd1000, 1'b1, 16'd0,      3, 1'b1);
    frame("up4", 16'd1000, -16'sd1000, 1'b1, -16'sd500,  4, 1'b0);
    frame("wet", 16'd1000, -16'sd1000, 1'b1, -16'sd1000, 4, 1'b0);

    // Reversal mid-fade without a gain jump
    frame("dn1", 16'd1000, -16'sd1000, 1'b0, -16'sd1000, 3, 1'b1);
    frame("dn2", 16'd1000, -16'sd1000, 1'b0, -16'sd500,  2, 1'b1);
    frame("rev", 16'd1000, -16'sd1000, 1'b1, 16'd0,      3, 1'b1);

    // Walk down to g=1, then rounding: (0*1 + -1*3) >>> 2 = -1
    frame("dn3", 16'd1000, -16'sd1000, 1'b0, -16'sd500,  2, 1'b1);
    frame("dn4", 16'd1000, -16'sd1000, 1'b0, 16'd0,      1, 1'b1);
    frame("round", -16'sd1, 16'd0,     1'b0, -16'sd1,    0, 1'b0);

    // Extremes across the whole fade
    frame("ext0", 16'h8000, 16'h7FFF, 1'b1, 16'h8000, 1, 1'b1);
    frame("ext1", 16'h8000, 16'h7FFF, 1'b1, 16'hBFFF, 2, 1'b1);
    frame("ext2", 16'h8000, 16'h7FFF, 1'b1, 16'hFFFF, 3, 1'b1);
    frame("ext3", 16'h8000, 16'h7FFF, 1'b1, 16'h3FFF, 4, 1'b0);
    frame("ext4", 16'h8000, 16'h7FFF, 1'b1, 16'h7FFF, 4, 1'b0);

    // Back-to-back strobes from WET: mixes at g=4 then g=3
    @(posedge clk); #1;
    ready = 1'b1; dry_in = 16'd100; wet_in = 16'd200; change_en = 1'b0;
    @(posedge clk); #1;
    dry_in = 16'd400; wet_in = -16'sd400;
    @(posedge clk); #1;
    ready = 1'b0;
    check("b2b first valid", 32'(sample_valid), 32'd1);
    check("b2b first play",  32'(play_data),    32'({16'd200, 8'h00}));
    check("b2b gain",        32'(gain),         32'd2);
    @(posedge clk); #1;
    check("b2b second valid", 32'(sample_valid), 32'd1);
    check("b2b second play",  32'(play_data),    32'({16'hFF38, 8'h00}));
    @(posedge clk); #1;
    check("b2b after valid", 32'(sample_valid), 32'd0);

    // Reset one cycle after a strobe drops its pending sample
    ready = 1'b1; dry_in = 16'd1234; wet_in = 16'd4321; change_en = 1'b0;
    @(posedge clk); #1;
    ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("midrst valid",  32'(sample_valid), 32'd0);
    check("midrst play",   32'(play_data),    32'd0);
    check("midrst gain",   32'(gain),         32'd0);
    check("midrst fading", 32'(fading),       32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("postrst no_valid", 32'(sample_valid), 32'd0);
    end
    frame("postrst bypass", -16'sd5, 16'd7, 1'b0, -16'sd5, 0, 1'b0);
    frame("postrst start",  -16'sd5, 16'd7, 1'b1, -16'sd5, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_mix_ramp.md
Name: voice_mix_ramp

Overview:
- Output-side stage between the voice-change path and the codec play-data inputs.
- Crossfades between the dry recorded sample and the processed (pitch-shifted) sample when the change-enable switch toggles, so the switch does not click.
- Updates once per audio frame on the frame-ready strobe and produces the 24-bit word fed to both play channels.

Parameters:
- RAMP_LOG2, 8, log2 of the crossfade length in frames; fade length = 2^RAMP_LOG2 frames (256 frames ≈ 5.3 ms at 48 kHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ready  in  1  one-cycle strobe, one per audio frame; dry_in and wet_in are valid in that cycle
- dry_in  in  16  signed two's-complement unprocessed sample
- wet_in  in  16  signed two's-complement processed sample
- change_en  in  1  level: 1 selects the processed path, 0 selects bypass
- play_data  out  24  mixed sample {mix[15:0], 8'd0}; held between updates
- sample_valid  out  1  one-cycle pulse when play_data updates
- fading  out  1  high while a crossfade is in progress
- gain  out  RAMP_LOG2+1  current wet gain g, range 0..2^RAMP_LOG2; debug and verification only

Behaviour:
- Reset, which overrides everything including a fade in progress: state=BYPASS, g=0, play_data=0, sample_valid=0, fading=0. The pipeline is flushed, and any sample_valid pending at reset is dropped.
- All decisions are taken only in cycles where ready=1. change_en is ignored between strobes.
- Let F = 2^RAMP_LOG2.
- States and transitions on each ready strobe:
  - BYPASS (g=0): if change_en=1, go to FADE_UP, fading=1.
  - FADE_UP: if change_en=0, go to FADE_DN without jumping g. Else if g+1 == F, go to WET, fading=0.
  - WET (g=F): if change_en=0, go to FADE_DN, fading=1.
  - FADE_DN: if change_en=1, go to FADE_UP without jumping g. Else if g-1 == 0, go to BYPASS, fading=0.
- Gain update on a ready strobe:
  - The sample on that strobe is mixed using g before the update.
  - g then changes by +1 in FADE_UP, by −1 in FADE_DN, and holds in BYPASS and WET.
  - g saturates at 0 and at F.
  - The state entered on a strobe governs the step applied on that same strobe. Example: BYPASS with change_en=1 mixes with g=0 and sets g=1.
- Mix arithmetic:
  - mix = (wet_in*g + dry_in*(F−g)) >>> RAMP_LOG2.
  - Signed, with an intermediate width of 16+RAMP_LOG2+2 bits.
  - The shift is arithmetic, so results round toward −inf.
  - Because the weights sum to F, the result always fits in 16 bits; no saturation logic is required.
- Pipeline and latency:
  - Stage 1, registered in the ready cycle: the two products.
  - Stage 2: sum and shift into play_data.
  - sample_valid pulses exactly 2 cycles after ready, together with the new play_data.
  - Back-to-back ready strobes (minimum spacing 1 cycle) must each produce their own sample_valid, with no drops.
- Endpoint exactness:
  - In BYPASS (g=0), play_data = {dry_in, 8'd0} bit-exact.
  - In WET (g=F), play_data = {wet_in, 8'd0} bit-exact.
- fading and gain are registered and change in the cycle after the ready strobe.

Test Plan:
- Reset, then RAMP_LOG2=2 (F=4), change_en=0, ready with dry=1000 and wet=−1000 → 2 cycles later play_data={16'd1000, 8'd0}, sample_valid=1 for 1 cycle, gain=0, fading=0.
- Set change_en=1 and issue 5 ready strobes with dry=1000, wet=−1000 → mixes 1000, 500, 0, −500, −1000; gain sequence 1, 2, 3, 4, 4; fading high after strobe 1 and low after strobe 4.
- From WET, set change_en=0 for 2 strobes, then change_en=1 → gain 3, 2, then 3 with no jump; fading stays 1.
- Rounding: F=4, g=1, dry=−1, wet=0 → (−3)>>>2 = −1, so play_data = 24'hFFFF00.
- Extremes: dry=−32768, wet=32767, g=2 → (65534−65536)>>>2 = −1; no overflow at g=0 (−32768) or g=4 (32767).
- Assert reset mid-fade with a ready issued 1 cycle earlier → no sample_valid follows; after reset gain=0, state BYPASS, play_data=0. Back-to-back ready on consecutive cycles → two consecutive sample_valid pulses, each with its own mixed value.
